// File: rtl/finn_rtl_krnl_example_pkg.sv
// ============================================================================
// Module   : finn_rtl_krnl_example_pkg
// Brief    : Shared state encoding and lane-count helper for the example kernel.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package finn_rtl_krnl_example_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic int unsigned num_lanes(input int unsigned data_w,
                                              input int unsigned lane_w);
        return data_w / lane_w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/finn_rtl_krnl_example_stream_gen.sv
// ============================================================================
// Module   : finn_rtl_krnl_example_stream_gen
// Brief    : AXI4-Stream source emitting an incrementing lane pattern with
//            programmable run length and tlast packet framing.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module finn_rtl_krnl_example_stream_gen
    import finn_rtl_krnl_example_pkg::*;
#(
    parameter int unsigned C_AXIS_TDATA_WIDTH = 512,
    parameter int unsigned C_ADDER_BIT_WIDTH  = 32,
    parameter int unsigned C_COUNT_WIDTH      = 32
) (
    input  logic                              m_axis_aclk,
    input  logic                              m_axis_aresetn,
    input  logic                              ctrl_start,
    input  logic [C_COUNT_WIDTH-1:0]          ctrl_num_beats,
    input  logic [C_COUNT_WIDTH-1:0]          ctrl_beats_per_pkt,
    input  logic [C_ADDER_BIT_WIDTH-1:0]      ctrl_seed,
    output logic                              ctrl_busy,
    output logic                              ctrl_done,
    output logic                              m_axis_tvalid,
    input  logic                              m_axis_tready,
    output logic [C_AXIS_TDATA_WIDTH-1:0]     m_axis_tdata,
    output logic [C_AXIS_TDATA_WIDTH/8-1:0]   m_axis_tkeep,
    output logic                              m_axis_tlast
);

    localparam int unsigned LP_NUM_LANES = num_lanes(C_AXIS_TDATA_WIDTH, C_ADDER_BIT_WIDTH);
    localparam logic [C_ADDER_BIT_WIDTH-1:0] LP_BASE_STEP = C_ADDER_BIT_WIDTH'(LP_NUM_LANES);
    localparam logic [C_COUNT_WIDTH-1:0]     LP_CNT_ONE   = C_COUNT_WIDTH'(1);
    localparam logic [C_COUNT_WIDTH-1:0]     LP_CNT_ZERO  = '0;

    state_e                            state_q;
    logic [C_COUNT_WIDTH-1:0]          num_beats_q;
    logic [C_COUNT_WIDTH-1:0]          bpp_q;
    logic [C_COUNT_WIDTH-1:0]          beat_idx_q;
    logic [C_COUNT_WIDTH-1:0]          pkt_cnt_q;
    logic [C_ADDER_BIT_WIDTH-1:0]      base_q;
    logic                              tvalid_q;
    logic                              tlast_q;
    logic [C_AXIS_TDATA_WIDTH-1:0]     tdata_q;
    logic [C_AXIS_TDATA_WIDTH/8-1:0]   tkeep_q;
    logic                              busy_q;
    logic                              done_q;

    logic [C_COUNT_WIDTH-1:0]          beat_idx_d;
    logic [C_COUNT_WIDTH-1:0]          pkt_cnt_d;
    logic [C_ADDER_BIT_WIDTH-1:0]      base_d;
    logic                              tlast_d;
    logic [C_AXIS_TDATA_WIDTH-1:0]     tdata_d;
    logic [C_COUNT_WIDTH-1:0]          w_nb_sel;
    logic [C_COUNT_WIDTH-1:0]          w_bpp_sel;
    logic                              w_start;
    logic                              w_hs;
    logic                              w_final;

    // Describe the beat that will be loaded next: beat 0 on start, else the successor.
    always_comb begin
        w_start   = (state_q == ST_IDLE) && ctrl_start;
        w_hs      = tvalid_q && m_axis_tready;
        w_final   = (beat_idx_q == (num_beats_q - LP_CNT_ONE));
        base_d    = base_q + LP_BASE_STEP;
        beat_idx_d = beat_idx_q + LP_CNT_ONE;
        pkt_cnt_d = tlast_q ? LP_CNT_ZERO : (pkt_cnt_q + LP_CNT_ONE);
        w_nb_sel  = num_beats_q;
        w_bpp_sel = bpp_q;
        if (w_start) begin
            base_d     = ctrl_seed;
            beat_idx_d = LP_CNT_ZERO;
            pkt_cnt_d  = LP_CNT_ZERO;
            w_nb_sel   = ctrl_num_beats;
            w_bpp_sel  = ctrl_beats_per_pkt;
        end
        tlast_d = ((w_bpp_sel != LP_CNT_ZERO) && (pkt_cnt_d == (w_bpp_sel - LP_CNT_ONE)))
               || (beat_idx_d == (w_nb_sel - LP_CNT_ONE));
    end

    for (genvar gi = 0; gi < LP_NUM_LANES; gi++) begin : g_lane
        assign tdata_d[gi*C_ADDER_BIT_WIDTH +: C_ADDER_BIT_WIDTH] =
            base_d + C_ADDER_BIT_WIDTH'(gi);
    end

    always_ff @(posedge m_axis_aclk) begin
        if (!m_axis_aresetn) begin
            state_q     <= ST_IDLE;
            num_beats_q <= '0;
            bpp_q       <= '0;
            beat_idx_q  <= '0;
            pkt_cnt_q   <= '0;
            base_q      <= '0;
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
            tdata_q     <= '0;
            tkeep_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (ctrl_start) begin
                        num_beats_q <= ctrl_num_beats;
                        bpp_q       <= ctrl_beats_per_pkt;
                        busy_q      <= 1'b1;
                        if (ctrl_num_beats == LP_CNT_ZERO) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q    <= ST_RUN;
                            tvalid_q   <= 1'b1;
                            tlast_q    <= tlast_d;
                            tdata_q    <= tdata_d;
                            tkeep_q    <= '1;
                            base_q     <= base_d;
                            beat_idx_q <= beat_idx_d;
                            pkt_cnt_q  <= pkt_cnt_d;
                        end
                    end
                end
                ST_RUN: begin
                    if (w_hs) begin
                        if (w_final) begin
                            state_q  <= ST_DONE;
                            tvalid_q <= 1'b0;
                            tlast_q  <= 1'b0;
                            done_q   <= 1'b1;
                        end else begin
                            tlast_q    <= tlast_d;
                            tdata_q    <= tdata_d;
                            base_q     <= base_d;
                            beat_idx_q <= beat_idx_d;
                            pkt_cnt_q  <= pkt_cnt_d;
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign ctrl_busy     = busy_q;
    assign ctrl_done     = done_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tkeep  = tkeep_q;
    assign m_axis_tlast  = tlast_q;

endmodule

`default_nettype wire

// File: tb/tb_finn_rtl_krnl_example_stream_gen.sv
// ============================================================================
// Module   : tb_finn_rtl_krnl_example_stream_gen
// Brief    : Randomized self-checking bench for the stream generator.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_finn_rtl_krnl_example_stream_gen;

    localparam int DW = 512;
    localparam int LW = 32;
    localparam int CW = 32;
    localparam int NL = DW / LW;
    localparam int KW = DW / 8;

    logic          clk = 1'b0;
    logic          rstn;
    logic          ctrl_start;
    logic [CW-1:0] ctrl_num_beats;
    logic [CW-1:0] ctrl_beats_per_pkt;
    logic [LW-1:0] ctrl_seed;
    logic          ctrl_busy;
    logic          ctrl_done;
    logic          tvalid;
    logic          tready;
    logic [DW-1:0] tdata;
    logic [KW-1:0] tkeep;
    logic          tlast;

    always #5 clk = ~clk;

    finn_rtl_krnl_example_stream_gen #(
        .C_AXIS_TDATA_WIDTH (DW),
        .C_ADDER_BIT_WIDTH  (LW),
        .C_COUNT_WIDTH      (CW)
    ) u_dut (
        .m_axis_aclk        (clk),
        .m_axis_aresetn     (rstn),
        .ctrl_start         (ctrl_start),
        .ctrl_num_beats     (ctrl_num_beats),
        .ctrl_beats_per_pkt (ctrl_beats_per_pkt),
        .ctrl_seed          (ctrl_seed),
        .ctrl_busy          (ctrl_busy),
        .ctrl_done          (ctrl_done),
        .m_axis_tvalid      (tvalid),
        .m_axis_tready      (tready),
        .m_axis_tdata       (tdata),
        .m_axis_tkeep       (tkeep),
        .m_axis_tlast       (tlast)
    );

    int n_checks = 0;
    int n_errors = 0;
    logic [DW-1:0] beat0_cap;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Lane i of beat k is simply seed + k*lanes + i, truncated to the lane width.
    function automatic logic [DW-1:0] ref_beat(input logic [LW-1:0] seed, input int unsigned k);
        logic [DW-1:0] v;
        for (int i = 0; i < NL; i++) v[i*LW +: LW] = seed + LW'(k * NL + i);
        return v;
    endfunction

    function automatic logic ref_last(input int unsigned k, input int unsigned nb,
                                      input int unsigned bpp);
        return ((bpp != 0) && ((k % bpp) == bpp - 1)) || (k == nb - 1);
    endfunction

    task automatic start_run(input logic [LW-1:0] seed, input int unsigned nb,
                             input int unsigned bpp);
        ctrl_seed          = seed;
        ctrl_num_beats     = nb;
        ctrl_beats_per_pkt = bpp;
        ctrl_start         = 1'b1;
        @(posedge clk);
        #1;
        ctrl_start         = 1'b0;
        ctrl_seed          = $urandom;
        ctrl_num_beats     = $urandom;
        ctrl_beats_per_pkt = $urandom;
    endtask

    task automatic monitor(input logic [LW-1:0] seed, input int unsigned nb,
                           input int unsigned bpp, input int ready_pct, input bit poke);
        int unsigned   k = 0;
        int            cyc = 0;
        bit            stalled = 0;
        bit            finished = 0;
        logic [DW-1:0] sd;
        logic          sl;
        while (!finished && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                chk("first_valid", tvalid, nb != 0);
                if (nb == 0) chk("zero_done", ctrl_done, 1'b1);
            end
            if (stalled) begin
                chk("stall_valid", tvalid, 1'b1);
                chk("stall_data", tdata, sd);
                chk("stall_last", tlast, sl);
                chk("stall_keep", tkeep, {KW{1'b1}});
            end
            stalled = 0;
            if (tvalid) begin
                chk("run_busy", ctrl_busy, 1'b1);
                if (tready) begin
                    chk($sformatf("data_b%0d", k), tdata, ref_beat(seed, k));
                    chk($sformatf("last_b%0d", k), tlast, ref_last(k, nb, bpp));
                    chk("keep", tkeep, {KW{1'b1}});
                    if (k == 0) beat0_cap = tdata;
                    k++;
                end else begin
                    stalled = 1;
                    sd = tdata;
                    sl = tlast;
                end
            end
            if (ctrl_done) begin
                chk("done_valid", tvalid, 1'b0);
                chk("done_busy", ctrl_busy, 1'b1);
                chk("beat_count", k, nb);
                finished = 1;
            end
            @(posedge clk);
            #1;
            tready     = ($urandom_range(99) < ready_pct);
            ctrl_start = poke && !finished && (k == 2);
            if (ctrl_start) ctrl_seed = $urandom;
        end
        if (!finished) chk("timeout", 0, 1);
        ctrl_start = 1'b0;
        @(negedge clk);
        chk("idle_busy", ctrl_busy, 1'b0);
        chk("idle_done", ctrl_done, 1'b0);
        chk("idle_valid", tvalid, 1'b0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rstn               = 1'b0;
        ctrl_start         = 1'b0;
        ctrl_num_beats     = '0;
        ctrl_beats_per_pkt = '0;
        ctrl_seed          = '0;
        tready             = 1'b1;
        beat0_cap          = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", tvalid, 1'b0);
        chk("rst_last", tlast, 1'b0);
        chk("rst_data", tdata, '0);
        chk("rst_keep", tkeep, '0);
        chk("rst_busy", ctrl_busy, 1'b0);
        chk("rst_done", ctrl_done, 1'b0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // Basic run, full throughput
        tready = 1'b1;
        start_run(32'h0, 4, 2);
        monitor(32'h0, 4, 2, 100, 0);

        // Backpressure
        tready = 1'b0;
        start_run(32'h100, 10, 3);
        monitor(32'h100, 10, 3, 50, 0);

        // Zero length
        start_run(32'h5, 0, 2);
        monitor(32'h5, 0, 2, 100, 0);

        // Lane wrap
        tready    = 1'b1;
        beat0_cap = '0;
        start_run(32'hFFFF_FFF8, 1, 0);
        monitor(32'hFFFF_FFF8, 1, 0, 100, 0);
        chk("wrap_lane7", beat0_cap[7*LW +: LW], 32'hFFFF_FFFF);
        chk("wrap_lane8", beat0_cap[8*LW +: LW], 32'h0000_0000);
        chk("wrap_lane15", beat0_cap[15*LW +: LW], 32'h0000_0007);

        // Reset abort after two beats
        tready = 1'b1;
        start_run(32'h0, 8, 0);
        @(negedge clk);
        chk("abort_b0", tdata, ref_beat(32'h0, 0));
        @(negedge clk);
        chk("abort_b1", tdata, ref_beat(32'h0, 1));
        @(posedge clk);
        #1;
        rstn = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        @(negedge clk);
        chk("abort_valid", tvalid, 1'b0);
        chk("abort_busy", ctrl_busy, 1'b0);
        repeat (5) begin
            @(negedge clk);
            chk("abort_no_done", ctrl_done, 1'b0);
            chk("abort_no_valid", tvalid, 1'b0);
        end
        @(posedge clk);
        #1;
        start_run(32'h0, 3, 0);
        monitor(32'h0, 3, 0, 100, 0);

        // Start pulse and seed change while running are ignored
        tready = 1'b1;
        start_run(32'h55, 5, 0);
        monitor(32'h55, 5, 0, 70, 1);

        // Random runs
        repeat (6) begin
            logic [LW-1:0] s;
            int unsigned   nb;
            int unsigned   bpp;
            s   = $urandom;
            nb  = $urandom_range(1, 12);
            bpp = $urandom_range(0, 4);
            tready = $urandom_range(1);
            start_run(s, nb, bpp);
            monitor(s, nb, bpp, 60, 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
